// File: rtl/riscr_pkg.sv
// Shared RISC4R definitions: R-type opcode, team ALU operation codes, sequencer states.
package riscr_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'b0000,
        ALU_SUB     = 4'b0001,
        ALU_SLL     = 4'b0010,
        ALU_SLT     = 4'b0011,
        ALU_SLTU    = 4'b0100,
        ALU_XOR     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_OR      = 4'b1000,
        ALU_AND     = 4'b1001,
        ALU_INVALID = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_e;

endpackage

// File: rtl/rtype_exec_ctrl_if.sv
// Fetch handshake, register-file, ALU and status signals of the R-type sequencer.
// slave = sequencer side, master = surrounding datapath/fetch side.
interface rtype_exec_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    logic              instr_valid;
    logic [31:0]       instr;
    logic              instr_ready;
    logic              flush;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              illegal;
    logic              busy;
    logic [CNT_W-1:0]  retired_cnt;
    logic [CNT_W-1:0]  illegal_cnt;

    modport slave (
        input  instr_valid, instr, flush, rs1_data, rs2_data, alu_result,
        output instr_ready, rs1_addr, rs2_addr, alu_op, alu_a, alu_b,
               wb_en, wb_addr, wb_data, illegal, busy, retired_cnt, illegal_cnt
    );

    modport master (
        output instr_valid, instr, flush, rs1_data, rs2_data, alu_result,
        input  instr_ready, rs1_addr, rs2_addr, alu_op, alu_a, alu_b,
               wb_en, wb_addr, wb_data, illegal, busy, retired_cnt, illegal_cnt
    );
endinterface

// File: rtl/rtype_decode.sv
// Combinational R-type decoder: {opcode, func7, func3} -> ALU op code and legality.
// Zero latency; no handshake, reusable by the pipelined core.
module rtype_decode
    import riscr_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [6:0] i_func7,
    input  logic [2:0] i_func3,
    output alu_op_e    o_alu_op,
    output logic       o_legal
);
    alu_op_e w_op;

    always_comb begin
        w_op = ALU_INVALID;
        case ({i_func7, i_func3})
            10'h000: w_op = ALU_ADD;
            10'h100: w_op = ALU_SUB;
            10'h001: w_op = ALU_SLL;
            10'h002: w_op = ALU_SLT;
            10'h003: w_op = ALU_SLTU;
            10'h004: w_op = ALU_XOR;
            10'h005: w_op = ALU_SRL;
            10'h105: w_op = ALU_SRA;
            10'h006: w_op = ALU_OR;
            10'h007: w_op = ALU_AND;
            default: w_op = ALU_INVALID;
        endcase
    end

    assign o_alu_op = w_op;
    assign o_legal  = (i_opcode == OPCODE_RTYPE) && (w_op != ALU_INVALID);
endmodule

// File: rtl/rtype_exec_ctrl.sv
// Multi-cycle R-type sequencer: DECODE, READ, EXEC, WB; write-back 4 cycles after accept.
// Backpressure: instr_ready only in IDLE, so throughput is one instruction per 5 cycles.
module rtype_exec_ctrl
    import riscr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    rtype_exec_ctrl_if.slave  bus
);
    state_e            r_state;
    state_e            w_next;
    logic [31:0]       r_instr;
    alu_op_e           r_dec_op;
    logic [3:0]        r_alu_op;
    logic [4:0]        r_rd;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_result;
    logic [CNT_W-1:0]  r_retired_cnt;
    logic [CNT_W-1:0]  r_illegal_cnt;

    alu_op_e           w_alu_op;
    logic              w_legal;
    logic              w_ready;
    logic              w_accept;
    logic              w_latch;
    logic              w_illegal;
    logic              w_retire;
    logic              w_wb_en;

    rtype_decode u_decode (
        .i_opcode (r_instr[6:0]),
        .i_func7  (r_instr[31:25]),
        .i_func3  (r_instr[14:12]),
        .o_alu_op (w_alu_op),
        .o_legal  (w_legal)
    );

    assign w_ready = (r_state == S_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // flush wins over every other transition so an aborted op never retires or flags
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_latch   = 1'b0;
        w_illegal = 1'b0;
        w_retire  = 1'b0;
        w_wb_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid && w_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.flush) begin
                    w_next = S_IDLE;
                end else if (!w_legal) begin
                    w_illegal = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_latch = 1'b1;
                    w_next  = S_READ;
                end
            end
            S_READ:  w_next = bus.flush ? S_IDLE : S_EXEC;
            S_EXEC:  w_next = bus.flush ? S_IDLE : S_WB;
            S_WB: begin
                w_next = S_IDLE;
                if (!bus.flush) begin
                    w_retire = 1'b1;
                    w_wb_en  = (r_rd != 5'd0);
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr       <= '0;
            r_dec_op      <= ALU_ADD;
            r_alu_op      <= '0;
            r_rd          <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_result      <= '0;
            r_retired_cnt <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_instr <= bus.instr;
            end
            if (w_latch) begin
                r_dec_op <= w_alu_op;
                r_rd     <= r_instr[11:7];
                r_rs1    <= r_instr[19:15];
                r_rs2    <= r_instr[24:20];
            end
            // ALU inputs change only on entry to EXEC and hold afterwards
            if (r_state == S_READ) begin
                r_op_a   <= bus.rs1_data;
                r_op_b   <= bus.rs2_data;
                r_alu_op <= r_dec_op;
            end
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_result;
            end
            if (w_illegal) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
            if (w_retire) begin
                r_retired_cnt <= r_retired_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.rs1_addr    = r_rs1;
    assign bus.rs2_addr    = r_rs2;
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_a       = r_op_a;
    assign bus.alu_b       = r_op_b;
    assign bus.wb_en       = w_wb_en;
    assign bus.wb_addr     = r_rd;
    assign bus.wb_data     = r_result;
    assign bus.illegal     = w_illegal;
    assign bus.retired_cnt = r_retired_cnt;
    assign bus.illegal_cnt = r_illegal_cnt;
endmodule

// File: doc/rtype_exec_ctrl.md
Name: rtype_exec_ctrl

Overview:
Multi-cycle sequencer for R-type integer instructions in the RISC4R core. Accepts one 32-bit instruction per valid/ready handshake and decodes opcode/func3/func7 into the team ALU operation code. Sequences register-file read, ALU execute and write-back, and flags illegal encodings. Sits between the fetch stage and the existing register file, ALU and ALU-control datapath.

Parameters:
DATA_W, 32, operand/result width
CNT_W, 16, width of retired/illegal counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
instr_valid  input  1  instruction available
instr  input  32  instruction word
instr_ready  output  1  controller can accept (IDLE only)
flush  input  1  synchronous abort of in-flight instruction
rs1_addr  output  5  register-file read address 1
rs2_addr  output  5  register-file read address 2
rs1_data  input  DATA_W  register-file read data 1 (combinational read)
rs2_data  input  DATA_W  register-file read data 2
alu_op  output  4  ALU operation code
alu_a  output  DATA_W  ALU operand A
alu_b  output  DATA_W  ALU operand B
alu_result  input  DATA_W  ALU result (combinational)
wb_en  output  1  register-file write enable
wb_addr  output  5  write-back register
wb_data  output  DATA_W  write-back data
illegal  output  1  one-cycle pulse on undecodable instruction
busy  output  1  high in any state except IDLE
retired_cnt  output  CNT_W  instructions written back (incl. rd=x0)
illegal_cnt  output  CNT_W  illegal instructions seen

Behaviour:
- Reset (async, rst=1): state IDLE; instruction/operand/result registers, alu_op, rs*_addr, wb_* , illegal, counters all 0; instr_ready=1 once rst deasserts.
- FSM IDLE -> DECODE -> READ -> EXEC -> WB -> IDLE; one state per cycle, no stalls.
- IDLE: instr_ready=1. instr_valid&instr_ready at edge latches instr, goes to DECODE.
- DECODE: opcode!=0110011 or {func7,func3} not in table -> illegal=1 for this cycle, illegal_cnt+1, next IDLE. Otherwise latch alu_op, rd, rs1, rs2 -> READ.
- Op table {func7,func3}->alu_op: 0x000 ADD 0000; 0x100 SUB 0001; 0x001 SLL 0010; 0x002 SLT 0011; 0x003 SLTU 0100; 0x004 XOR 0101; 0x005 SRL 0110; 0x105 SRA 0111; 0x006 OR 1000; 0x007 AND 1001; invalid code 1111 (never driven to ALU).
- READ: rs1_addr/rs2_addr driven from latched fields; rs1_data/rs2_data captured into operand registers at end of cycle.
- EXEC: alu_op, alu_a, alu_b driven from registers; alu_result captured at end of cycle.
- WB: wb_en = (rd!=0) & !flush; wb_addr=rd, wb_data=captured result; retired_cnt+1 unless flush. Next IDLE.
- Latency: accept edge in cycle 0 -> wb_en high in cycle 4; throughput 1 instruction / 5 cycles.
- flush: in any non-IDLE state forces IDLE at next edge, no wb_en, no counter increment (flush in DECODE of illegal instr suppresses illegal pulse and count). flush in IDLE ignored; handshake still allowed.
- Outside their states rs*_addr, alu_* hold last values; wb_en=0, illegal=0.
- Counters wrap modulo 2^CNT_W.
- Mid-operation async reset: immediate IDLE, no write-back, counters cleared.

Decomposition:
- Package riscr_pkg: OPCODE_RTYPE constant, alu_op_e enum (ADD..AND, INVALID=1111), state_e enum.
- Sub-module rtype_decode: pure combinational {opcode,func7,func3} -> {alu_op, legal}; shared with future pipelined core.

Test Plan:
- x1=5, x2=7; instr 0x002081B3 (add x3,x1,x2) -> wb_en in cycle 4, wb_addr=3, wb_data=12, retired_cnt=1.
- x6=3, x7=10; 0x407302B3 (sub x5,x6,x7) -> alu_op=0001 in EXEC, wb_data=0xFFFFFFF9 to x5.
- 0x00108093 (addi, opcode 0x13) -> illegal pulse in cycle 1, illegal_cnt=1, no wb_en, instr_ready again in cycle 2.
- 0x00208033 (add x0,x1,x2) -> wb_en stays 0, retired_cnt still increments.
- flush asserted in EXEC of sra instruction -> returns IDLE, no wb_en, retired_cnt unchanged; next add completes normally.
- rst pulsed during READ -> all outputs 0 immediately, busy=0, subsequent instruction retires with correct result.
